// File: rtl/dlfloat_result_serializer_if.sv
// Byte-serializer handshake bundle: 16-bit word intake from the MAC and
// 8-bit valid/ready byte stream toward the pin-limited consumer.
interface dlfloat_result_serializer_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        out_last;

  // master = MAC producer plus byte consumer; slave = the serializer itself
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dlfloat_result_serializer.sv
// Buffers 16-bit DLFloat MAC results in a small FIFO and streams each word
// out as two bytes over an 8-bit valid/ready port; data passes bit-exact.
module dlfloat_result_serializer #(
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  dlfloat_result_serializer_if.slave bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    BYTE0 = 1'b0,
    BYTE1 = 1'b1
  } phase_e;

  phase_e          state;
  phase_e          state_next;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            not_empty;
  logic            full;
  logic            push;
  logic            drop;
  logic            xfer;
  logic            pop;
  logic [15:0]     head_word;

  // Full is judged purely on occupancy, so a word arriving while the head is
  // popping in the same cycle is still dropped (no pass-through).
  assign not_empty = (count_q != '0);
  assign full      = (count_q == FULL_COUNT);
  assign push      = bus.in_valid && !full && !clear;
  assign drop      = bus.in_valid && full && !clear;
  assign xfer      = not_empty && bus.out_ready;
  assign pop       = xfer && (state == BYTE1);
  assign head_word = mem[rd_ptr];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_err <= 1'b0;
    end else if (clear) begin
      overflow_err <= 1'b0;
    end else if (drop) begin
      overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BYTE0;
    end else begin
      state <= state_next;
    end
  end

  // Phase only advances on an accepted byte; an empty FIFO never transfers,
  // so the phase is guaranteed to sit at BYTE0 whenever nothing is stored.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = BYTE0;
    end else if (xfer) begin
      case (state)
        BYTE0:   state_next = BYTE1;
        BYTE1:   state_next = BYTE0;
        default: state_next = BYTE0;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = !full;
    bus.out_valid = not_empty;
    bus.out_last  = (state == BYTE1);
    bus.out_data  = 8'h00;
    if (not_empty) begin
      if ((state == BYTE0) == LSB_FIRST) begin
        bus.out_data = head_word[7:0];
      end else begin
        bus.out_data = head_word[15:8];
      end
    end
  end

endmodule

// File: tb/tb_dlfloat_result_serializer.sv
// Directed self-checking bench for dlfloat_result_serializer: one LSB-first
// and one MSB-first instance share the clock and are driven in turn.
module tb_dlfloat_result_serializer;

  logic       clk;
  logic       rst;
  logic       clear_a;
  logic       clear_b;
  logic [2:0] count_a;
  logic [2:0] count_b;
  logic       err_a;
  logic       err_b;
  int         checks_total;
  int         checks_passed;

  dlfloat_result_serializer_if bus_a ();
  dlfloat_result_serializer_if bus_b ();

  dlfloat_result_serializer #(.DEPTH(4), .LSB_FIRST(1'b1)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear_a),
    .bus          (bus_a),
    .count        (count_a),
    .overflow_err (err_a)
  );

  dlfloat_result_serializer #(.DEPTH(4), .LSB_FIRST(1'b0)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear_b),
    .bus          (bus_b),
    .count        (count_b),
    .overflow_err (err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic ready);
    bus_a.in_valid  = valid;
    bus_a.in_data   = data;
    bus_a.out_ready = ready;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Checks the byte stream of DUT A for one word in LSB-first order.
  task automatic drainWordA(input string tag, input logic [15:0] word);
    checkOutput({tag, "_lo"}, {24'h0, bus_a.out_data}, {24'h0, word[7:0]});
    checkOutput({tag, "_lo_last"}, {31'h0, bus_a.out_last}, 32'd0);
    nextCycle();
    checkOutput({tag, "_hi"}, {24'h0, bus_a.out_data}, {24'h0, word[15:8]});
    checkOutput({tag, "_hi_last"}, {31'h0, bus_a.out_last}, 32'd1);
    nextCycle();
  endtask

  initial begin
    logic [15:0] model_q[$];
    logic        model_phase;
    int          pushed;
    int          nbytes;
    logic [7:0]  exp_byte;
    logic [15:0] word;

    checks_total  = 0;
    checks_passed = 0;
    rst     = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = 16'h0000;
    bus_b.out_ready = 1'b0;

    #2;
    checkOutput("rst_in_ready", {31'h0, bus_a.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'h0, bus_a.out_valid}, 32'd0);
    checkOutput("rst_out_data", {24'h0, bus_a.out_data}, 32'h0);
    checkOutput("rst_out_last", {31'h0, bus_a.out_last}, 32'd0);
    checkOutput("rst_count", {29'h0, count_a}, 32'd0);
    checkOutput("rst_err", {31'h0, err_a}, 32'd0);
    #5;
    rst = 1'b1;
    nextCycle();

    // Test 1: single word, LSB first, consumer always ready.
    applyStimulus(1'b1, 16'h3E00, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t1_valid", {31'h0, bus_a.out_valid}, 32'd1);
    checkOutput("t1_count1", {29'h0, count_a}, 32'd1);
    drainWordA("t1", 16'h3E00);
    checkOutput("t1_count0", {29'h0, count_a}, 32'd0);
    checkOutput("t1_empty", {31'h0, bus_a.out_valid}, 32'd0);
    checkOutput("t1_empty_data", {24'h0, bus_a.out_data}, 32'h0);

    // Test 2: MSB-first instance.
    bus_b.in_valid  = 1'b1;
    bus_b.in_data   = 16'hBF12;
    bus_b.out_ready = 1'b1;
    nextCycle();
    bus_b.in_valid = 1'b0;
    checkOutput("t2_b0", {24'h0, bus_b.out_data}, 32'hBF);
    checkOutput("t2_b0_last", {31'h0, bus_b.out_last}, 32'd0);
    nextCycle();
    checkOutput("t2_b1", {24'h0, bus_b.out_data}, 32'h12);
    checkOutput("t2_b1_last", {31'h0, bus_b.out_last}, 32'd1);
    nextCycle();
    checkOutput("t2_empty", {31'h0, bus_b.out_valid}, 32'd0);
    checkOutput("t2_count", {29'h0, count_b}, 32'd0);

    // Test 3: overfill with stalled consumer, then drain in order.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0);
      #1;
      checkOutput($sformatf("t3_in_ready%0d", i), {31'h0, bus_a.in_ready}, (i <= 4) ? 32'd1 : 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t3_count_full", {29'h0, count_a}, 32'd4);
    checkOutput("t3_err", {31'h0, err_a}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      drainWordA($sformatf("t3_w%0d", i), 16'(i));
    end
    checkOutput("t3_count_end", {29'h0, count_a}, 32'd0);

    // Test 4: full FIFO, push alongside byte1 pop is still dropped.
    applyStimulus(1'b0, 16'h0000, 1'b0);
    clear_a = 1'b1;
    nextCycle();
    clear_a = 1'b0;
    checkOutput("t4_err_cleared", {31'h0, err_a}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h1100 + 16'(i), 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 16'h0000, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 16'hDEAD, 1'b1);
    #1;
    checkOutput("t4_in_ready", {31'h0, bus_a.in_ready}, 32'd0);
    checkOutput("t4_phase1", {31'h0, bus_a.out_last}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t4_count", {29'h0, count_a}, 32'd3);
    checkOutput("t4_err", {31'h0, err_a}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      drainWordA($sformatf("t4_w%0d", i), 16'h1100 + 16'(i));
    end
    checkOutput("t4_count_end", {29'h0, count_a}, 32'd0);

    // Test 5: toggling consumer over 8 words through the wrapping FIFO.
    model_phase = 1'b0;
    pushed = 0;
    nbytes = 0;
    for (int cyc = 0; cyc < 200 && nbytes < 16; cyc++) begin
      word = {4'hA, 4'(pushed), 4'h5, 4'(pushed + 1)};
      applyStimulus((pushed < 8) && (model_q.size() < 4), word, cyc[0]);
      #1;
      checkOutput($sformatf("t5_valid_c%0d", cyc), {31'h0, bus_a.out_valid},
                  {31'h0, model_q.size() > 0});
      checkOutput($sformatf("t5_count_c%0d", cyc), {29'h0, count_a}, model_q.size());
      if (model_q.size() > 0) begin
        exp_byte = model_phase ? model_q[0][15:8] : model_q[0][7:0];
        checkOutput($sformatf("t5_data_c%0d", cyc), {24'h0, bus_a.out_data}, {24'h0, exp_byte});
        checkOutput($sformatf("t5_last_c%0d", cyc), {31'h0, bus_a.out_last}, {31'h0, model_phase});
        if (bus_a.out_ready) begin
          nbytes++;
          if (model_phase) begin
            void'(model_q.pop_front());
          end
          model_phase = ~model_phase;
        end
      end
      if (bus_a.in_valid) begin
        model_q.push_back(word);
        pushed++;
      end
      nextCycle();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t5_bytes", nbytes, 32'd16);
    checkOutput("t5_err", {31'h0, err_a}, 32'd1);

    // Test 6: clear mid-word with a colliding push, then async reset mid-word.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'h7700 + 16'(i), 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 16'h0000, 1'b1);
    nextCycle();
    checkOutput("t6_phase1", {31'h0, bus_a.out_last}, 32'd1);
    applyStimulus(1'b1, 16'h5555, 1'b1);
    clear_a = 1'b1;
    nextCycle();
    clear_a = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t6_count", {29'h0, count_a}, 32'd0);
    checkOutput("t6_valid", {31'h0, bus_a.out_valid}, 32'd0);
    checkOutput("t6_err", {31'h0, err_a}, 32'd0);
    checkOutput("t6_last", {31'h0, bus_a.out_last}, 32'd0);

    applyStimulus(1'b1, 16'h1234, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t6_mid_last", {31'h0, bus_a.out_last}, 32'd1);
    checkOutput("t6_mid_data", {24'h0, bus_a.out_data}, 32'h12);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_in_ready", {31'h0, bus_a.in_ready}, 32'd1);
    checkOutput("t6_rst_valid", {31'h0, bus_a.out_valid}, 32'd0);
    checkOutput("t6_rst_data", {24'h0, bus_a.out_data}, 32'h0);
    checkOutput("t6_rst_last", {31'h0, bus_a.out_last}, 32'd0);
    checkOutput("t6_rst_count", {29'h0, count_a}, 32'd0);
    checkOutput("t6_rst_err", {31'h0, err_a}, 32'd0);
    #3;
    rst = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("t6_post_count", {29'h0, count_a}, 32'd0);
    checkOutput("t6_post_valid", {31'h0, bus_a.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
